// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-store responder.
//   respStatus_e : verdict encoding driven onto the 2-bit status port
//   LOG_ENTRY_W  : width of one store-log entry ({address, data})
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } respStatus_e;

  localparam int unsigned LOG_ENTRY_W = 64;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready pop side.
//   clk, reset       : clock, async active-high reset (empties the FIFO)
//   push, pushData   : write strobe and data; ignored when full unless a pop
//                      happens on the same edge
//   full, empty      : occupancy flags
//   popValid         : head entry present (== !empty)
//   popReady         : consumer accepts the head this cycle
//   popData          : head entry, stable until popped
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  output logic             full,
  output logic             empty,
  output logic             popValid,
  input  logic             popReady,
  output logic [WIDTH-1:0] popData
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign popValid = !empty;
  assign popData  = mem[rdPtr];

  // On a full FIFO the pop frees the slot the push writes into.
  assign doPop  = popValid && popReady;
  assign doPush = push && (!full || doPop);

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/dmem_store_responder.sv
// Responder for the CPU data-store bus: word-addressed data RAM with
// combinational read, memory-mapped TOHOST verdict word, pass/fail/timeout
// verdict FSM and a log of every accepted store drained by the host.
//   clk, reset                  : clock, async active-high reset
//   MemWrite, DataAdr, WriteData: store strobe, byte address, store data
//   ReadData                    : combinational load data
//   done, pass, status          : registered verdict (0 RUN,1 PASS,2 FAIL,3 TIMEOUT)
//   fail_adr                    : address of the store that caused FAIL
//   store_count                 : accepted stores, saturating
//   log_valid/log_ready         : store-log head handshake
//   log_adr, log_data           : store-log head entry
//   log_overflow                : sticky, a log push was dropped
module dmem_store_responder
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned LOG_DEPTH   = 8,
  parameter logic [31:0] TOHOST_ADDR = 32'd100,
  parameter logic [31:0] PASS_VALUE  = 32'd25,
  parameter int unsigned TIMEOUT     = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        done,
  output logic        pass,
  output logic [1:0]  status,
  output logic [31:0] fail_adr,
  output logic [15:0] store_count,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_adr,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT - 1);

  logic [31:0] ram [DEPTH];

  respStatus_e stateQ, stateNext;
  logic [31:0] failAdrQ, failAdrNext;
  logic [31:0] wdogQ, wdogNext;
  logic [31:0] tohostQ, tohostNext;

  logic accepted, isTohost, aligned, inRange, ramWe;
  logic logFull, logEmpty;
  logic [LOG_ENTRY_W-1:0] logHead;

  assign accepted = MemWrite && (stateQ == ST_RUN);
  assign isTohost = (DataAdr == TOHOST_ADDR);
  assign aligned  = (DataAdr[1:0] == 2'b00);
  assign inRange  = (DataAdr < RAM_BYTES);
  // TOHOST decode takes priority even when it falls inside the RAM window.
  assign ramWe    = accepted && aligned && inRange && !isTohost;

  always_comb begin
    stateNext   = stateQ;
    failAdrNext = failAdrQ;
    wdogNext    = wdogQ;
    tohostNext  = tohostQ;
    unique case (stateQ)
      ST_RUN: begin
        // A verdict-giving store beats a watchdog expiring on the same edge.
        if (accepted && isTohost) begin
          tohostNext = WriteData;
          if (WriteData == PASS_VALUE) begin
            stateNext = ST_PASS;
          end else begin
            stateNext   = ST_FAIL;
            failAdrNext = DataAdr;
          end
        end else if (accepted && !ramWe) begin
          stateNext   = ST_FAIL;
          failAdrNext = DataAdr;
        end else if (wdogQ == WDOG_LAST) begin
          stateNext = ST_TIMEOUT;
        end else begin
          wdogNext = wdogQ + 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ       <= ST_RUN;
      failAdrQ     <= '0;
      wdogQ        <= '0;
      tohostQ      <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      store_count  <= '0;
      log_overflow <= 1'b0;
    end else begin
      stateQ   <= stateNext;
      failAdrQ <= failAdrNext;
      wdogQ    <= wdogNext;
      tohostQ  <= tohostNext;
      done     <= (stateNext != ST_RUN);
      pass     <= (stateNext == ST_PASS);
      if (accepted && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
      if (accepted && logFull && !log_ready) log_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ramWe) ram[DataAdr[AW+1:2]] <= WriteData;
  end

  always_comb begin
    ReadData = '0;
    if (isTohost)     ReadData = tohostQ;
    else if (inRange) ReadData = ram[DataAdr[AW+1:2]];
  end

  assign status   = stateQ;
  assign fail_adr = failAdrQ;

  sync_fifo #(
    .WIDTH (LOG_ENTRY_W),
    .DEPTH (LOG_DEPTH)
  ) uLog (
    .clk      (clk),
    .reset    (reset),
    .push     (accepted),
    .pushData ({DataAdr, WriteData}),
    .full     (logFull),
    .empty    (logEmpty),
    .popValid (log_valid),
    .popReady (log_ready),
    .popData  (logHead)
  );

  assign log_adr  = logHead[63:32];
  assign log_data = logHead[31:0];

  logic unusedEmpty;
  assign unusedEmpty = logEmpty;

endmodule

// File: tb/tb_dmem_store_responder.sv
module tb_dmem_store_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        done, pass;
  logic [1:0]  status;
  logic [31:0] fail_adr;
  logic [15:0] store_count;
  logic        log_valid;
  logic        log_ready = 1'b0;
  logic [31:0] log_adr, log_data;
  logic        log_overflow;

  int unsigned vecCount = 0;
  int unsigned missCount = 0;

  always #5 clk = ~clk;

  dmem_store_responder #(
    .DEPTH       (64),
    .LOG_DEPTH   (8),
    .TOHOST_ADDR (32'd100),
    .PASS_VALUE  (32'd25),
    .TIMEOUT     (1000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .DataAdr      (DataAdr),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .done         (done),
    .pass         (pass),
    .status       (status),
    .fail_adr     (fail_adr),
    .store_count  (store_count),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_adr      (log_adr),
    .log_data     (log_data),
    .log_overflow (log_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; MemWrite = 1'b0; log_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents a store for exactly one rising edge, optionally popping the log too.
  task automatic store(input logic [31:0] adr, input logic [31:0] data, input logic pop);
    MemWrite = 1'b1; DataAdr = adr; WriteData = data; log_ready = pop;
    @(negedge clk);
    MemWrite = 1'b0; log_ready = 1'b0;
  endtask

  task automatic readChk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    DataAdr = adr;
    #1 chk(tag, ReadData, exp);
  endtask

  task automatic popChk(input string tag, input logic [31:0] adr, input logic [31:0] data);
    chk({tag, ".valid"}, 32'(log_valid), 32'd1);
    chk({tag, ".adr"}, log_adr, adr);
    chk({tag, ".data"}, log_data, data);
    log_ready = 1'b1;
    @(negedge clk);
    log_ready = 1'b0;
  endtask

  initial begin
    // Reset state and PASS flow
    doReset();
    chk("rst.status", 32'(status), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.pass", 32'(pass), 32'd0);
    chk("rst.fail_adr", fail_adr, 32'd0);
    chk("rst.count", 32'(store_count), 32'd0);
    chk("rst.log_valid", 32'(log_valid), 32'd0);
    chk("rst.overflow", 32'(log_overflow), 32'd0);
    store(32'd96, 32'd7, 1'b0);
    chk("p1.status_run", 32'(status), 32'd0);
    readChk("p1.ram96", 32'd96, 32'd7);
    readChk("p1.ram96_lowbits", 32'd99, 32'd7);
    store(32'd100, 32'd25, 1'b0);
    chk("p1.status", 32'(status), 32'd1);
    chk("p1.pass", 32'(pass), 32'd1);
    chk("p1.done", 32'(done), 32'd1);
    chk("p1.count", 32'(store_count), 32'd2);
    readChk("p1.tohost", 32'd100, 32'd25);
    popChk("p1.pop0", 32'd96, 32'd7);
    popChk("p1.pop1", 32'd100, 32'd25);
    chk("p1.empty", 32'(log_valid), 32'd0);

    // Same-cycle read of a word being written returns the old value
    doReset();
    store(32'd0, 32'h11, 1'b0);
    MemWrite = 1'b1; DataAdr = 32'd0; WriteData = 32'h22;
    #1 chk("rw.old", ReadData, 32'h11);
    @(negedge clk);
    MemWrite = 1'b0;
    readChk("rw.new", 32'd0, 32'h22);

    // FAIL via TOHOST, later stores ignored
    doReset();
    store(32'd100, 32'd26, 1'b0);
    chk("f1.status", 32'(status), 32'd2);
    chk("f1.fail_adr", fail_adr, 32'd100);
    chk("f1.pass", 32'(pass), 32'd0);
    chk("f1.done", 32'(done), 32'd1);
    store(32'd0, 32'd5, 1'b0);
    readChk("f1.ram0_kept", 32'd0, 32'h22);
    chk("f1.count", 32'(store_count), 32'd1);
    popChk("f1.pop0", 32'd100, 32'd26);
    chk("f1.empty", 32'(log_valid), 32'd0);

    // Misaligned and out-of-range stores
    doReset();
    store(32'h62, 32'd1, 1'b0);
    chk("f2.status", 32'(status), 32'd2);
    chk("f2.fail_adr", fail_adr, 32'h62);
    chk("f2.count", 32'(store_count), 32'd1);
    doReset();
    store(32'h400, 32'd1, 1'b0);
    chk("f3.status", 32'(status), 32'd2);
    chk("f3.fail_adr", fail_adr, 32'h400);
    readChk("f3.read_oor", 32'h400, 32'd0);
    chk("f3.log_valid", 32'(log_valid), 32'd1);

    // Watchdog: TIMEOUT on edge 1000, PASS store on edge 1000 wins
    doReset();
    repeat (999) @(negedge clk);
    chk("t1.run_999", 32'(status), 32'd0);
    @(negedge clk);
    chk("t1.status", 32'(status), 32'd3);
    chk("t1.done", 32'(done), 32'd1);
    chk("t1.pass", 32'(pass), 32'd0);
    doReset();
    repeat (999) @(negedge clk);
    store(32'd100, 32'd25, 1'b0);
    chk("t2.status", 32'(status), 32'd1);
    chk("t2.pass", 32'(pass), 32'd1);

    // Log FIFO fill, push+pop on full, overflow
    doReset();
    for (int i = 0; i < 8; i++) store(32'(4 * i), 32'(i + 1), 1'b0);
    chk("o1.overflow0", 32'(log_overflow), 32'd0);
    chk("o1.head_adr", log_adr, 32'd0);
    @(negedge clk);
    chk("o1.head_stable", log_data, 32'd1);
    store(32'd32, 32'd100, 1'b1);
    chk("o1.pushpop_ovf", 32'(log_overflow), 32'd0);
    store(32'd36, 32'd101, 1'b0);
    store(32'd40, 32'd102, 1'b0);
    chk("o1.overflow", 32'(log_overflow), 32'd1);
    chk("o1.count", 32'(store_count), 32'd11);
    for (int i = 1; i < 8; i++) popChk("o1.drain", 32'(4 * i), 32'(i + 1));
    popChk("o1.drain_last", 32'd32, 32'd100);
    chk("o1.empty", 32'(log_valid), 32'd0);
    chk("o1.ovf_sticky", 32'(log_overflow), 32'd1);

    // Asynchronous reset mid-run
    doReset();
    store(32'd96, 32'd7, 1'b0);
    store(32'd4, 32'd1, 1'b0);
    store(32'h62, 32'd3, 1'b0);
    chk("r1.pre_status", 32'(status), 32'd2);
    chk("r1.pre_count", 32'(store_count), 32'd3);
    #1 reset = 1'b1;
    #1;
    chk("r1.status", 32'(status), 32'd0);
    chk("r1.done", 32'(done), 32'd0);
    chk("r1.fail_adr", fail_adr, 32'd0);
    chk("r1.count", 32'(store_count), 32'd0);
    chk("r1.log_valid", 32'(log_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    readChk("r1.ram96", 32'd96, 32'd7);
    readChk("r1.tohost0", 32'd100, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/dmem_store_responder.md
Name: dmem_store_responder

Overview:
- Responder end of the CPU data-store bus (MemWrite/DataAdr/WriteData).
- Holds word-addressed data RAM with combinational read and decodes a memory-mapped TOHOST word.
- Runs a pass/fail/timeout verdict state machine and logs every accepted store into a FIFO drained by a valid/ready host port.
- Sits beside the CPU inside top; replaces ad-hoc bench store checking with synthesizable status.

Parameters:
- DEPTH, 64: data RAM words; must be a power of 2.
- LOG_DEPTH, 8: store-log FIFO entries; must be a power of 2.
- TOHOST_ADDR, 100: byte address of the verdict word.
- PASS_VALUE, 25: value written to TOHOST that means pass.
- TIMEOUT, 1000: cycles allowed in RUN before timeout.

Ports:
- clk in 1: rising-edge clock.
- reset in 1: asynchronous, active-high reset.
- MemWrite in 1: store strobe from CPU.
- DataAdr in 32: byte address.
- WriteData in 32: store data.
- ReadData out 32: load data, combinational.
- done out 1: verdict reached.
- pass out 1: verdict is PASS.
- status out 2: 0 RUN, 1 PASS, 2 FAIL, 3 TIMEOUT.
- fail_adr out 32: address of the store that caused FAIL.
- store_count out 16: accepted stores, saturating.
- log_valid out 1: FIFO non-empty.
- log_ready in 1: host pop.
- log_adr out 32: head entry address.
- log_data out 32: head entry data.
- log_overflow out 1: sticky flag, a push was dropped.

Behaviour:
- Reset (async, any time incl. mid-run): status=RUN, done=0, pass=0, fail_adr=0, store_count=0, watchdog=0, FIFO emptied, log_overflow=0, tohost_q=0. RAM contents are not reset.
- Store is "accepted" when MemWrite=1 and status=RUN at the rising edge.
- Accepted store, aligned, DataAdr==TOHOST_ADDR:
  - tohost_q<=WriteData.
  - WriteData==PASS_VALUE -> PASS, else -> FAIL with fail_adr<=DataAdr.
  - Store is logged and counted.
- Accepted store, aligned, DataAdr < DEPTH*4: RAM[DataAdr[log2(DEPTH)+1:2]]<=WriteData; logged and counted.
- Accepted store, misaligned (DataAdr[1:0]!=0) or out of range (not TOHOST, >= DEPTH*4): -> FAIL, fail_adr<=DataAdr, RAM untouched, still logged and counted.
- TOHOST inside the RAM range: the TOHOST decode wins and RAM is not written.
- Verdict latency: status/done/pass update at the edge that samples the store and are visible one cycle after the store is presented.
- Watchdog: increments each RUN cycle without a verdict. Reaching TIMEOUT-1 -> TIMEOUT state. A store that gives a verdict on that same edge wins over the timeout.
- PASS, FAIL and TIMEOUT are terminal until reset. Stores in these states are ignored: no RAM write, no log, no count.
- done = (status!=RUN); pass = (status==PASS); both registered.
- ReadData, combinational:
  - DataAdr==TOHOST_ADDR -> tohost_q.
  - In range -> RAM word; address bits [1:0] are ignored for reads.
  - Otherwise -> 0.
- RAM write is synchronous; a read of the same word in the same cycle returns old data.
- store_count saturates at 16'hFFFF.
- Log FIFO:
  - Push {DataAdr,WriteData} on each accepted store; pop on log_valid&&log_ready.
  - Full + push without pop: entry dropped, log_overflow<=1 (sticky).
  - Full + push + pop same edge: both happen, occupancy unchanged, no overflow.
  - Empty + push: log_valid rises the next cycle; there is no same-cycle bypass.
  - Head outputs remain stable while log_valid=1 and log_ready=0.
  - Pointers wrap modulo LOG_DEPTH.
  - FIFO keeps draining in terminal states.

Decomposition:
- Package dmem_resp_pkg:
  - status encoding (ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT).
  - log entry width constant (64).
- Sub-module sync_fifo (WIDTH, DEPTH):
  - valid/ready pop, push with full/empty outputs.
  - Simultaneous push/pop on full is legal.
  - Async active-high reset.
  - Reused for the store log.

Test Plan:
- Store 7@96, then 25@100 -> RAM[24]=7; status=1, pass=1 one cycle after the 100 store; store_count=2; log pops (96,7),(100,25).
- Store 26@100 -> status=2, fail_adr=100, pass=0. A later store 5@0 is ignored: ReadData@0 unchanged, store_count stays 1.
- Store 1@0x62 (misaligned) -> FAIL, fail_adr=0x62. Separately, store 1@0x400 with DEPTH=64 -> FAIL, fail_adr=0x400.
- No stores for TIMEOUT=1000 cycles -> status=3 at cycle 1000. A PASS store on exactly that edge -> status=1 instead.
- log_ready=0 with 10 accepted RAM stores, LOG_DEPTH=8 -> 8 entries kept, log_overflow=1. Then pop and push on a full FIFO in the same cycle -> occupancy stays 8, no new overflow.
- Assert reset mid-run after 3 stores -> all outputs take reset values immediately without waiting for a clock edge. RAM retains data: a read of 96 returns the prior 7.
